// File: rtl/tdm_mux_4to1_pkg.sv
// Shared constants and types for the 4:1 time-division multiplexer.
package tdm_mux_4to1_pkg;

  localparam int NLANES = 4;
  localparam int SELW   = 2;

  typedef logic [SELW-1:0] lane_idx_t;

  // Converts a one-hot grant vector into the lane index; returns 0 when no bit is set.
  function automatic lane_idx_t grant_to_idx(input logic [NLANES-1:0] g);
    grant_to_idx = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (g[i]) grant_to_idx = lane_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: searches ptr, ptr+1, ... (mod 4) for the first request.
module rr_arbiter4
  import tdm_mux_4to1_pkg::*;
(
  input  logic [NLANES-1:0] request,
  input  lane_idx_t         ptr,
  input  logic              enable,
  output logic [NLANES-1:0] grant
);

  lane_idx_t idx;
  logic      found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NLANES; k++) begin
      // 2-bit addition wraps lane 3 back to lane 0.
      idx = ptr + lane_idx_t'(k);
      if (enable && !found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_4to1.sv
// Transmit-side 4:1 TDM multiplexer: round-robin grants lanes into one output register
// that carries the data plus its 2-bit source lane index.
module tdm_mux_4to1
  import tdm_mux_4to1_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] D0,
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  input  logic [W-1:0] D3,
  input  logic         V0,
  input  logic         V1,
  input  logic         V2,
  input  logic         V3,
  output logic         R0,
  output logic         R1,
  output logic         R2,
  output logic         R3,
  output logic [W-1:0] D,
  output logic         S1,
  output logic         S0,
  output logic         VALID,
  input  logic         READY
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // lanes use V<i>/R<i>, the output uses VALID/READY. The output register may load a new
  // item whenever it is empty or being drained in the same cycle (load), which gives
  // one item per cycle with no bubble.

  logic [W-1:0]      d_q;
  lane_idx_t         sel_q;
  logic              valid_q;
  lane_idx_t         ptr_q;

  logic              load;
  logic [NLANES-1:0] request;
  logic [NLANES-1:0] grant;
  lane_idx_t         gidx;
  logic [W-1:0]      lane_d;

  // Gating with rst_n keeps all lane readies low while reset is held.
  assign load    = (!valid_q || READY) && rst_n;
  assign request = {V3, V2, V1, V0};

  rr_arbiter4 u_arb (
    .request (request),
    .ptr     (ptr_q),
    .enable  (load),
    .grant   (grant)
  );

  assign gidx = grant_to_idx(grant);

  always_comb begin
    lane_d = D0;
    case (gidx)
      2'd0:    lane_d = D0;
      2'd1:    lane_d = D1;
      2'd2:    lane_d = D2;
      2'd3:    lane_d = D3;
      default: lane_d = D0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      if (|grant) begin
        d_q     <= lane_d;
        sel_q   <= gidx;
        valid_q <= 1'b1;
        ptr_q   <= gidx + lane_idx_t'(1);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign {R3, R2, R1, R0} = grant;
  assign D     = d_q;
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign VALID = valid_q;

endmodule
